// File: rtl/instr_enc_pkg.sv
// Shared MSP430 instruction encoding constants, FSM states and helpers.
// Also used by instr_dec so both sides agree on field codes.
package instr_enc_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned FMT_W  = 2;
  localparam int unsigned KIND_W = 2;

  localparam logic [FMT_W-1:0] FMT_I  = 2'd1;
  localparam logic [FMT_W-1:0] FMT_II = 2'd2;
  localparam logic [FMT_W-1:0] FMT_J  = 2'd3;

  localparam logic [KIND_W-1:0] WK_OP  = 2'd0;
  localparam logic [KIND_W-1:0] WK_SRC = 2'd1;
  localparam logic [KIND_W-1:0] WK_DST = 2'd2;

  localparam logic [2:0] SOP_RRC  = 3'd0;
  localparam logic [2:0] SOP_SWPB = 3'd1;
  localparam logic [2:0] SOP_RRA  = 3'd2;
  localparam logic [2:0] SOP_SXT  = 3'd3;
  localparam logic [2:0] SOP_PUSH = 3'd4;
  localparam logic [2:0] SOP_CALL = 3'd5;
  localparam logic [2:0] SOP_RETI = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_OPW, ST_SRCX, ST_DSTX} state_e;

  // Extension words plus which of them the current instruction still owes.
  typedef struct packed {
    logic [WORD_W-1:0] src_ext;
    logic [WORD_W-1:0] dst_ext;
    logic              need_src;
    logic              need_dst;
  } ext_t;

  function automatic logic sub_op_valid(input logic [2:0] sop);
    case (sop)
      SOP_RRC, SOP_SWPB, SOP_RRA, SOP_SXT,
      SOP_PUSH, SOP_CALL, SOP_RETI: sub_op_valid = 1'b1;
      default:                      sub_op_valid = 1'b0;
    endcase
  endfunction

  function automatic logic desc_legal(input logic [FMT_W-1:0] fmt, input logic [3:0] op);
    case (fmt)
      FMT_I:   desc_legal = (op >= 4'd4);
      FMT_II:  desc_legal = sub_op_valid(op[2:0]);
      FMT_J:   desc_legal = 1'b1;
      default: desc_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] op_word(
    input logic [FMT_W-1:0] fmt,
    input logic [3:0]       op,
    input logic [3:0]       src,
    input logic [3:0]       dst,
    input logic [1:0]       as_mode,
    input logic             ad,
    input logic             bw,
    input logic [9:0]       jmp_off
  );
    case (fmt)
      FMT_I:   op_word = {op, src, ad, bw, as_mode, dst};
      FMT_II:  op_word = {6'b000100, op[2:0], bw, as_mode, dst};
      FMT_J:   op_word = {3'b001, op[2:0], jmp_off};
      default: op_word = '0;
    endcase
  endfunction

endpackage

// File: rtl/instr_ext_need.sv
// Decides which extension words an instruction carries.
// R3 and R2/As=1x are constant-generator sources and never take an extension.
module instr_ext_need
  import instr_enc_pkg::*;
(
  input  logic [1:0] fmt,
  input  logic [2:0] op,
  input  logic [3:0] src,
  input  logic [3:0] dst,
  input  logic [1:0] as_mode,
  input  logic       ad,
  output logic       need_src,
  output logic       need_dst
);

  logic [3:0] sreg;
  logic       src_mode_ext;

  assign sreg         = (fmt == FMT_II) ? dst : src;
  assign src_mode_ext = ((as_mode == 2'b01) && (sreg != 4'd3)) ||
                        ((as_mode == 2'b11) && (sreg == 4'd0));

  assign need_src = src_mode_ext &&
                    ((fmt == FMT_I) || ((fmt == FMT_II) && (op != SOP_RETI)));
  assign need_dst = (fmt == FMT_I) && ad;

endmodule

// File: rtl/instr_enc.sv
// Serialises a decoded MSP430 instruction descriptor into its word stream
// (opcode, optional src ext, optional dst ext), each tagged with its address.
module instr_enc
  import instr_enc_pkg::*;
#(
  parameter logic [15:0] RST_ADDR = 16'hC000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [3:0]  op,
  input  logic [3:0]  src,
  input  logic [3:0]  dst,
  input  logic [1:0]  as_mode,
  input  logic        ad,
  input  logic        bw,
  input  logic [15:0] src_ext,
  input  logic [15:0] dst_ext,
  input  logic [9:0]  jmp_off,
  output logic [15:0] word,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        word_last,
  output logic [1:0]  word_kind,
  output logic [15:0] word_addr,
  input  logic        load_addr,
  input  logic [15:0] addr_in,
  output logic        err
);

  state_e            state, state_next;
  ext_t              ext_q;
  logic [WORD_W-1:0] word_d;
  logic              valid_d, last_d, err_d;
  logic [KIND_W-1:0] kind_d;
  logic              hs, accept, legal_in, need_src_in, need_dst_in;

  instr_ext_need u_ext_need (
    .fmt     (fmt),
    .op      (op[2:0]),
    .src     (src),
    .dst     (dst),
    .as_mode (as_mode),
    .ad      (ad),
    .need_src(need_src_in),
    .need_dst(need_dst_in)
  );

  assign hs       = word_valid && word_ready;
  assign in_ready = (state == ST_IDLE) || (hs && word_last);
  assign accept   = in_valid && in_ready;
  assign legal_in = desc_legal(fmt, op);

  // Next state and next output word; a new descriptor may overlap the last handshake.
  always_comb begin
    state_next = state;
    word_d     = word;
    valid_d    = word_valid;
    last_d     = word_last;
    kind_d     = word_kind;
    err_d      = 1'b0;
    if (hs) begin
      case (state)
        ST_OPW: begin
          if (ext_q.need_src) begin
            state_next = ST_SRCX;
            word_d     = ext_q.src_ext;
            kind_d     = WK_SRC;
            last_d     = !ext_q.need_dst;
          end else if (ext_q.need_dst) begin
            state_next = ST_DSTX;
            word_d     = ext_q.dst_ext;
            kind_d     = WK_DST;
            last_d     = 1'b1;
          end else begin
            state_next = ST_IDLE;
            valid_d    = 1'b0;
            last_d     = 1'b0;
          end
        end
        ST_SRCX: begin
          if (ext_q.need_dst) begin
            state_next = ST_DSTX;
            word_d     = ext_q.dst_ext;
            kind_d     = WK_DST;
            last_d     = 1'b1;
          end else begin
            state_next = ST_IDLE;
            valid_d    = 1'b0;
            last_d     = 1'b0;
          end
        end
        default: begin
          state_next = ST_IDLE;
          valid_d    = 1'b0;
          last_d     = 1'b0;
        end
      endcase
    end
    if (accept) begin
      if (legal_in) begin
        state_next = ST_OPW;
        word_d     = op_word(fmt, op, src, dst, as_mode, ad, bw, jmp_off);
        valid_d    = 1'b1;
        kind_d     = WK_OP;
        last_d     = !(need_src_in || need_dst_in);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      word       <= '0;
      word_valid <= 1'b0;
      word_last  <= 1'b0;
      word_kind  <= WK_OP;
      err        <= 1'b0;
      ext_q      <= '0;
    end else begin
      state      <= state_next;
      word       <= word_d;
      word_valid <= valid_d;
      word_last  <= last_d;
      word_kind  <= kind_d;
      err        <= err_d;
      if (accept && legal_in) begin
        ext_q <= '{src_ext: src_ext, dst_ext: dst_ext,
                   need_src: need_src_in, need_dst: need_dst_in};
      end
    end
  end

  // Address counter: an explicit load overrides the handshake increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_addr <= {RST_ADDR[15:1], 1'b0};
    end else if (load_addr) begin
      word_addr <= {addr_in[15:1], 1'b0};
    end else if (hs) begin
      word_addr <= word_addr + 16'd2;
    end
  end

endmodule
